ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
- AHB-Lite responder: a word-organised SRAM that answers transfers issued by core-side initiators through the interconnect.
- Decodes the address phase, inserts a programmable number of wait states and performs byte-laned writes and word reads.
- Issues the two-cycle ERROR response for illegal transfers.
- Default map is 0x4000_0000, which is the target region of the core traffic generator.

Parameters:
- HADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; fixed at 32 for this block
- BASE_ADDR, 32'h4000_0000, first byte address served
- DEPTH, 256, number of 32-bit words in the array
- WAIT_STATES, 1, cycles hreadyout is held low per OKAY data phase (0..15)

Ports:
- hclk  in  1  clock
- hresetn  in  1  asynchronous active-low reset
- hsel  in  1  slave select from the decoder
- haddr  in  HADDR_WIDTH  byte address
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size
- hburst  in  3  burst type; not used functionally
- hprot  in  4  protection; ignored
- hwdata  in  DATA_WIDTH  write data, valid in the data phase
- hwstrb  in  DATA_WIDTH/8  byte strobes, valid in the data phase
- hready  in  1  bus-level ready; qualifies the address phase
- hreadyout  out  1  slave ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_WIDTH  read data

Behaviour:
- Reset is hresetn, asynchronous, active-low; clock is hclk.
- Reset values: hreadyout=1, hresp=0, hrdata=0, state=IDLE, wait counter=0, captured phase cleared.
- Array contents are not reset.
- Address-phase accept: hsel && hready && htrans[1] (NONSEQ or SEQ). On accept, register haddr, hwrite and hsize, and evaluate the error condition.
- Error condition is any of:
  - haddr < BASE_ADDR, or haddr >= BASE_ADDR + 4*DEPTH;
  - hsize > 3'b010;
  - haddr not aligned to hsize.
- IDLE or BUSY with hsel=1 and hready=1: next cycle is a zero-wait OKAY.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
    - Accept with error -> ERR1.
    - Accept with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - Accept with WAIT_STATES=0 -> DATA.
  - WAIT: hreadyout=0, hresp=0. Counter decrements each cycle; at 0 -> DATA.
  - DATA: hreadyout=1, hresp=0, and the transfer completes this cycle.
    - Read: hrdata = mem[offset[..:2]].
    - Write: commit at the clock edge ending this cycle, byte lanes = hwstrb & size_lane_mask(addr[1:0], hsize).
    - A new accept in this cycle (pipelined) follows the same rules as from IDLE; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=1 -> ERR2.
  - ERR2: hreadyout=1, hresp=1. No write is committed. Any accept this cycle is ignored, because the master must cancel it; -> IDLE.
- Size lane mask:
  - byte: one lane, selected by addr[1:0];
  - half: lanes {1:0} or {3:2}, selected by addr[1];
  - word: all four lanes.
- hrdata is 0 in every cycle other than a DATA cycle of a read.
- Read-after-write with zero wait: the write has already committed before the read's DATA cycle, so the read returns the new data. No bypass path is needed.
- Back-to-back transfers with WAIT_STATES=0 sustain one transfer per cycle.
- hburst is ignored. WRAP and INCR bursts are handled as independent single transfers.
- hresetn asserted mid-transfer returns immediately to the reset values. A pending write is dropped.

Decomposition:
- ahb_pkg holds:
  - htrans_t enum {IDLE=0, BUSY=1, NONSEQ=2, SEQ=3};
  - HSIZE_BYTE/HALF/WORD constants;
  - HRESP_OKAY/HRESP_ERROR constants;
  - slave FSM state enum {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2}.
- Sub-module ahb_sram_array: DEPTH x 32 storage, byte-enable write port, asynchronous read port.
- FSM, decode and lane-mask logic stay in ahb_sram_slave.

Test Plan:
- Reset, then idle bus -> hreadyout=1, hresp=0, hrdata=0. Memory untouched.
- WAIT_STATES=1: NONSEQ write of 0x06070100 to 0x4000_0000, then NONSEQ read of the same address -> write data phase shows 1 low hreadyout cycle; read returns 0x06070100 with hresp=0.
- WAIT_STATES=0, pipelined burst: SEQ word writes to 0x4000_0004..0x4000_0010 (data 0x11..0x44), then reads -> one transfer per cycle, hreadyout never low, read-back matches.
- Byte write 0xAB to 0x4000_0021 over word 0x00000000 with hwstrb=4'hF -> read of 0x4000_0020 returns 0x0000AB00 (size mask overrides strobes).
- Errors, each followed by an OKAY transfer:
  - read of 0x4000_0400 (DEPTH=256): hreadyout 0 then 1 with hresp=1 on both cycles;
  - misaligned halfword read of 0x4000_0001: same two-cycle ERROR, no memory change;
  - the following OKAY transfer completes normally.
- hresetn pulsed low during the WAIT cycle of a write to 0x4000_0008 -> outputs return to reset values immediately; a subsequent read of 0x4000_0008 returns the prior contents, not the dropped data.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM responder state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } slv_state_t;

endpackage

// File: rtl/ahb_sram_array.sv
// Word-organised SRAM: byte-enable synchronous write, asynchronous read.
module ahb_sram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          hclk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH];

  // Byte-laned write; contents are deliberately not reset
  always_ff @(posedge hclk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: address decode, programmable wait states,
// byte-laned writes, word reads and the two-cycle ERROR response.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int                     HADDR_WIDTH = 32,
  parameter int                     DATA_WIDTH  = 32,
  parameter logic [HADDR_WIDTH-1:0] BASE_ADDR   = 32'h4000_0000,
  parameter int                     DEPTH       = 256,
  parameter int                     WAIT_STATES = 1
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    hsel,
  input  logic [HADDR_WIDTH-1:0]  haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic                    hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int                   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [HADDR_WIDTH:0] SPAN    = (HADDR_WIDTH + 1)'(4 * DEPTH);
  localparam logic [3:0]           WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // The size mask wins over hwstrb so a narrow write never touches other lanes
  function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
    case (sz)
      HSIZE_BYTE: lane_mask = 4'b0001 << a;
      HSIZE_HALF: lane_mask = a[1] ? 4'b1100 : 4'b0011;
      HSIZE_WORD: lane_mask = 4'b1111;
      default:    lane_mask = 4'b0000;
    endcase
  endfunction

  slv_state_t       state_r, state_nxt_s;
  logic [3:0]       cnt_r, cnt_nxt_s;
  logic [AW-1:0]    widx_r;
  logic [1:0]       lane_r;
  logic [2:0]       size_r;
  logic             write_r;
  logic             hreadyout_r, hresp_r;
  logic [HADDR_WIDTH:0] offset_s;
  logic             misalign_s, err_s, accept_s, capture_s, we_s;
  logic [3:0]       be_s;
  logic [31:0]      rdata_s;
  logic             unused_s;

  assign accept_s  = hsel && hready && htrans[1];
  assign capture_s = accept_s && ((state_r == S_IDLE) || (state_r == S_DATA));

  // Address decode and legality check of the incoming address phase
  always_comb begin
    offset_s = {1'b0, haddr} - {1'b0, BASE_ADDR};
    case (hsize)
      HSIZE_HALF: misalign_s = haddr[0];
      HSIZE_WORD: misalign_s = |haddr[1:0];
      default:    misalign_s = 1'b0;
    endcase
    err_s = (haddr < BASE_ADDR) || (offset_s >= SPAN) || (hsize > HSIZE_WORD) || misalign_s;
  end

  // Next-state and wait-counter logic; ERR2 drops any accept the master must cancel
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE, S_DATA: begin
        if (accept_s) begin
          if (err_s) begin
            state_nxt_s = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt_s = S_WAIT;
            cnt_nxt_s   = WS_LOAD;
          end else begin
            state_nxt_s = S_DATA;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = S_DATA;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      S_ERR1:  state_nxt_s = S_ERR2;
      S_ERR2:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, counter, captured phase and registered handshake outputs
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r     <= S_IDLE;
      cnt_r       <= 4'd0;
      widx_r      <= '0;
      lane_r      <= 2'b00;
      size_r      <= 3'b000;
      write_r     <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= HRESP_OKAY;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hreadyout_r <= !((state_nxt_s == S_WAIT) || (state_nxt_s == S_ERR1));
      hresp_r     <= ((state_nxt_s == S_ERR1) || (state_nxt_s == S_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
      if (capture_s) begin
        widx_r  <= offset_s[AW+1:2];
        lane_r  <= haddr[1:0];
        size_r  <= hsize;
        write_r <= hwrite;
      end
    end
  end

  assign we_s = (state_r == S_DATA) && write_r;
  assign be_s = we_s ? (hwstrb & lane_mask(lane_r, size_r)) : 4'b0000;

  ahb_sram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .hclk  (hclk),
    .we    (we_s),
    .waddr (widx_r),
    .wdata (hwdata),
    .be    (be_s),
    .raddr (widx_r),
    .rdata (rdata_s)
  );

  // Read data is driven only in the completing cycle of a read
  always_comb begin
    if ((state_r == S_DATA) && !write_r) begin
      hrdata = rdata_s;
    end else begin
      hrdata = '0;
    end
  end

  assign hreadyout = hreadyout_r;
  assign hresp     = hresp_r;
  assign unused_s  = ^{hburst, hprot, htrans[0], offset_s[HADDR_WIDTH:AW+2], offset_s[1:0]};

endmodule
